// File: rtl/rom_fetch_arbiter.sv
// Two-requester front end for the combinational instruction ROM: bounded-burst
// round-robin grant, registered ROM address and a fixed two-edge return path.
module rom_fetch_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 28,
  parameter int MAX_BURST = 4,
  parameter int PRIO      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic              valid0,
  output logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic              valid1,
  output logic [DATA_W-1:0] data1,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_instruction
);

  localparam int              BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);

  logic          owner_r;
  logic [BW-1:0] burst_r;
  logic          rsel_r;
  logic          rvld_r;
  logic          grant_s;
  logic          win_s;

  // Grant decision: a lone requester always wins; under contention the owner
  // keeps the port until its burst budget is spent.
  always_comb begin
    grant_s = 1'b0;
    win_s   = 1'b0;
    if (req0 && req1) begin
      grant_s = 1'b1;
      if (burst_r == BURST_MAX) begin
        win_s = ~owner_r;
      end else begin
        win_s = owner_r;
      end
    end else if (req0) begin
      grant_s = 1'b1;
      win_s   = 1'b0;
    end else if (req1) begin
      grant_s = 1'b1;
      win_s   = 1'b1;
    end else begin
      grant_s = 1'b0;
      win_s   = 1'b0;
    end
  end

  assign ack0 = grant_s & ~win_s;
  assign ack1 = grant_s & win_s;

  // Ownership and saturating burst count, updated on every transfer edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r <= 1'(PRIO);
      burst_r <= '0;
    end else if (grant_s) begin
      if (win_s == owner_r) begin
        if (burst_r != BURST_MAX) begin
          burst_r <= burst_r + BW'(1);
        end else begin
          burst_r <= burst_r;
        end
      end else begin
        owner_r <= win_s;
        burst_r <= BW'(1);
      end
    end else begin
      owner_r <= owner_r;
      burst_r <= burst_r;
    end
  end

  // Address stage: launch the winner's address to the ROM and tag the read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_address <= '0;
      rsel_r      <= 1'b0;
      rvld_r      <= 1'b0;
    end else if (grant_s) begin
      rom_address <= win_s ? addr1 : addr0;
      rsel_r      <= win_s;
      rvld_r      <= 1'b1;
    end else begin
      rom_address <= rom_address;
      rsel_r      <= rsel_r;
      rvld_r      <= 1'b0;
    end
  end

  // Return stage: steer the ROM word to the owner of the in-flight read.
  // Reset wins here too, so a read in flight at reset never produces a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      data0  <= '0;
      data1  <= '0;
    end else if (rvld_r) begin
      if (rsel_r) begin
        data1  <= rom_instruction;
        valid1 <= 1'b1;
        valid0 <= 1'b0;
      end else begin
        data0  <= rom_instruction;
        valid0 <= 1'b1;
        valid1 <= 1'b0;
      end
    end else begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
    end
  end

endmodule
